fadd_pre_aligner: RTL



---
 rtl/fadd_pre_aligner_pkg.sv | 26 ++
 rtl/fadd_pre_aligner_if.sv | 27 ++
 rtl/fadd_unpack.sv | 20 ++
 rtl/fadd_pre_aligner.sv | 118 +++++++++++
 4 files changed

// File: rtl/fadd_pre_aligner_pkg.sv
// Shared binary32 adder definitions: field widths, datapath geometry and the
// unpacked operand record used by the pre-aligner and the normaliser.
package fadd_pkg;

   localparam int unsigned EXP_W   = 8;
   localparam int unsigned FRAC_W  = 23;
   localparam int unsigned SIG_W   = 24;
   localparam int unsigned SUM_W   = 50;
   localparam int unsigned SIG_LSB = 25;

   localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;
   // Beyond this distance the smaller significand lies entirely below bit 0.
   localparam logic [EXP_W-1:0] MAX_SHIFT   = 8'd48;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [EXP_W-1:0] eexp;
      logic [SIG_W-1:0] sig;
   } unpacked_t;

   function automatic logic [SUM_W-1:0] place_sig(input logic [SIG_W-1:0] sig);
      return {1'b0, sig, {SIG_LSB{1'b0}}};
   endfunction

endpackage

// File: rtl/fadd_pre_aligner_if.sv
// Operand-in / aligned-sum-out handshake bundle of the adder front end.
interface fadd_pre_aligner_if;
   import fadd_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          in_a;
   logic [31:0]          in_b;
   logic                 in_op;
   logic                 out_valid;
   logic                 out_ready;
   logic [SUM_W-1:0]     out_mant;
   logic [EXP_W-1:0]     out_exp_max;
   logic                 out_sign;
   logic                 out_special;

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_mant, out_exp_max, out_sign, out_special
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_mant, out_exp_max, out_sign, out_special
   );

endinterface

// File: rtl/fadd_unpack.sv
// Splits one binary32 word into sign, raw/effective exponent and 24-bit
// significand; denormals get effective exponent 1 and no hidden bit.
module fadd_unpack
   import fadd_pkg::*;
(
   input  logic [31:0] op_i,
   output unpacked_t   unp_o
);

   logic hidden;

   always_comb begin
      hidden     = |op_i[30:23];
      unp_o.sign = op_i[31];
      unp_o.exp  = op_i[30:23];
      unp_o.eexp = hidden ? op_i[30:23] : 8'd1;
      unp_o.sig  = {hidden, op_i[22:0]};
   end

endmodule

// File: rtl/fadd_pre_aligner.sv
// Adder front end: orders operands by magnitude, right-aligns the smaller
// significand and adds/subtracts in a two-stage valid/ready pipeline.
module fadd_pre_aligner
   import fadd_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   fadd_pre_aligner_if.slave   bus
);

   logic s1_adv;
   logic s2_adv;

   logic [31:0] b_eff;
   unpacked_t   a_u;
   unpacked_t   b_u;
   unpacked_t   l_u;
   unpacked_t   s_u;
   logic        swap;

   logic             s1_valid_q;
   logic             s1_l_sign_q,   s1_l_sign_d;
   logic [EXP_W-1:0] s1_l_exp_q,    s1_l_exp_d;
   logic [SIG_W-1:0] s1_l_sig_q,    s1_l_sig_d;
   logic [SIG_W-1:0] s1_s_sig_q,    s1_s_sig_d;
   logic [EXP_W-1:0] s1_shift_q,    s1_shift_d;
   logic             s1_eff_sub_q,  s1_eff_sub_d;
   logic             s1_special_q,  s1_special_d;

   logic             s2_valid_q;
   logic [SUM_W-1:0] s2_mant_q,     s2_mant_d;
   logic [EXP_W-1:0] s2_exp_q;
   logic             s2_sign_q,     s2_sign_d;
   logic             s2_special_q;

   logic [SUM_W-1:0] l_al;
   logic [SUM_W-1:0] s_al;

   assign s2_adv = !s2_valid_q || bus.out_ready;
   assign s1_adv = !s1_valid_q || s2_adv;

   // Subtraction is folded into B's sign so stage 1 only sees an addition.
   assign b_eff = {bus.in_b[31] ^ bus.in_op, bus.in_b[30:0]};

   fadd_unpack u_unpack_a (.op_i(bus.in_a), .unp_o(a_u));
   fadd_unpack u_unpack_b (.op_i(b_eff),    .unp_o(b_u));

   always_comb begin
      swap         = b_eff[30:0] > bus.in_a[30:0];
      l_u          = swap ? b_u : a_u;
      s_u          = swap ? a_u : b_u;
      s1_l_sign_d  = l_u.sign;
      s1_l_exp_d   = l_u.exp;
      s1_l_sig_d   = l_u.sig;
      s1_s_sig_d   = s_u.sig;
      s1_shift_d   = l_u.eexp - s_u.eexp;
      s1_eff_sub_d = l_u.sign ^ s_u.sign;
      s1_special_d = (a_u.exp == EXP_SPECIAL) || (b_u.exp == EXP_SPECIAL);
   end

   always_comb begin
      l_al      = place_sig(s1_l_sig_q);
      s_al      = (s1_shift_q > MAX_SHIFT) ? '0 : (place_sig(s1_s_sig_q) >> s1_shift_q);
      s2_mant_d = s1_eff_sub_q ? (l_al - s_al) : (l_al + s_al);
      // Exact cancellation always yields +0.
      s2_sign_d = (s1_eff_sub_q && (s2_mant_d == '0)) ? 1'b0 : s1_l_sign_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_l_sign_q  <= 1'b0;
         s1_l_exp_q   <= '0;
         s1_l_sig_q   <= '0;
         s1_s_sig_q   <= '0;
         s1_shift_q   <= '0;
         s1_eff_sub_q <= 1'b0;
         s1_special_q <= 1'b0;
      end else if (s1_adv) begin
         s1_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            s1_l_sign_q  <= s1_l_sign_d;
            s1_l_exp_q   <= s1_l_exp_d;
            s1_l_sig_q   <= s1_l_sig_d;
            s1_s_sig_q   <= s1_s_sig_d;
            s1_shift_q   <= s1_shift_d;
            s1_eff_sub_q <= s1_eff_sub_d;
            s1_special_q <= s1_special_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q   <= 1'b0;
         s2_mant_q    <= '0;
         s2_exp_q     <= '0;
         s2_sign_q    <= 1'b0;
         s2_special_q <= 1'b0;
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_mant_q    <= s2_mant_d;
            s2_exp_q     <= s1_l_exp_q;
            s2_sign_q    <= s2_sign_d;
            s2_special_q <= s1_special_q;
         end
      end
   end

   assign bus.in_ready    = s1_adv;
   assign bus.out_valid   = s2_valid_q;
   assign bus.out_mant    = s2_mant_q;
   assign bus.out_exp_max = s2_exp_q;
   assign bus.out_sign    = s2_sign_q;
   assign bus.out_special = s2_special_q;

endmodule
